// File: rtl/alu_pkg.sv
// Shared types for the 32-bit ALU and its two-port sharing controller.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_AND  = 3'd0,
      ALU_OR   = 3'd1,
      ALU_ADD  = 3'd2,
      ALU_ZERO = 3'd3,
      ALU_ANDN = 3'd4,
      ALU_ORN  = 3'd5,
      ALU_SUB  = 3'd6,
      ALU_SLT  = 3'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } share_state_t;

endpackage

// File: rtl/alu.sv
// Combinational W-bit ALU: logic ops, wrapping add/sub, signed set-less-than.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  alu_op_t      f,
   output logic [W-1:0] y,
   output logic         zero
);

   always_comb begin
      y = '0;
      case (f)
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_ADD:  y = a + b;
         ALU_ZERO: y = '0;
         ALU_ANDN: y = a & ~b;
         ALU_ORN:  y = a | ~b;
         ALU_SUB:  y = a - b;
         ALU_SLT:  y = W'($signed(a) < $signed(b));
         default:  y = '0;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one alu between two requesters,
// with a per-port registered response and a completed-op counter.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned W     = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [W-1:0]     req_a0,
   input  logic [W-1:0]     req_b0,
   input  logic [W-1:0]     req_a1,
   input  logic [W-1:0]     req_b1,
   input  logic [2:0]       req_f0,
   input  logic [2:0]       req_f1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [W-1:0]     rsp_y,
   output logic             rsp_zero,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   share_state_t     state_q, state_d;
   logic             cur_q, cur_d;
   logic             last_grant_q, last_grant_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   alu_op_t          f_q, f_d;
   logic [W-1:0]     y_q, y_d;
   logic             zero_q, zero_d;
   logic [1:0]       rsp_valid_q, rsp_valid_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] ops_done_q, ops_done_d;

   logic             grant_c;
   logic [W-1:0]     alu_y;
   logic             alu_zero;

   alu #(.W(W)) u_alu (
      .a    (a_q),
      .b    (b_q),
      .f    (f_q),
      .y    (alu_y),
      .zero (alu_zero)
   );

   // On a tie the port that did not win last time takes the grant.
   always_comb begin
      grant_c = req_valid[1];
      if (req_valid == 2'b11) grant_c = ~last_grant_q;
   end

   assign req_ready = (state_q == ST_IDLE && (|req_valid)) ? (2'b01 << grant_c) : 2'b00;

   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      f_d          = f_q;
      y_d          = y_q;
      zero_d       = zero_q;
      ops_done_d   = ops_done_q;

      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               cur_d        = grant_c;
               last_grant_d = grant_c;
               a_d          = grant_c ? req_a1 : req_a0;
               b_d          = grant_c ? req_b1 : req_b0;
               f_d          = alu_op_t'(grant_c ? req_f1 : req_f0);
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            y_d     = alu_y;
            zero_d  = alu_zero;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready[cur_q]) begin
               ops_done_d = ops_done_q + CNT_W'(1);
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d      = (state_d != ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP) ? (2'b01 << cur_d) : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cur_q        <= 1'b0;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         f_q          <= ALU_AND;
         y_q          <= '0;
         zero_q       <= 1'b0;
         rsp_valid_q  <= 2'b00;
         busy_q       <= 1'b0;
         ops_done_q   <= '0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         f_q          <= f_d;
         y_q          <= y_d;
         zero_q       <= zero_d;
         rsp_valid_q  <= rsp_valid_d;
         busy_q       <= busy_d;
         ops_done_q   <= ops_done_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_y     = y_q;
   assign rsp_zero  = zero_q;
   assign busy      = busy_q;
   assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed table, corner sequences, random traffic.
module tb_alu_share_ctrl;

   localparam int unsigned W     = 32;
   localparam int unsigned CNT_W = 4;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   f;
      logic [W-1:0] y;
      logic         z;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [W-1:0]     req_a0, req_b0, req_a1, req_b1;
   logic [2:0]       req_f0, req_f1;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [W-1:0]     rsp_y;
   logic             rsp_zero;
   logic             busy;
   logic [CNT_W-1:0] ops_done;

   alu_share_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .req_f0    (req_f0),
      .req_f1    (req_f1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_zero  (rsp_zero),
      .busy      (busy),
      .ops_done  (ops_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Pending request per port, and the model's view of fairness and count.
   logic [W-1:0]     pa [2];
   logic [W-1:0]     pb [2];
   logic [2:0]       pf [2];
   logic [1:0]       pv;
   logic             lg;
   logic [CNT_W-1:0] cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] f);
      case (f)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd3:    return '0;
         3'd4:    return a & ~b;
         3'd5:    return a | ~b;
         3'd6:    return a - b;
         default: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      endcase
   endfunction

   task automatic apply();
      req_valid = pv;
      req_a0 = pa[0]; req_b0 = pb[0]; req_f0 = pf[0];
      req_a1 = pa[1]; req_b1 = pb[1]; req_f1 = pf[1];
   endtask

   // Called at a negedge in IDLE with the request applied; returns at the negedge back in IDLE.
   task automatic serve(input int p, input logic [W-1:0] ey, input logic ez, input int hold);
      logic [1:0] onehot;
      onehot = 2'b01 << p;
      #1;
      chk("accept_ready", 32'(req_ready), 32'(onehot));
      chk("accept_busy", 32'(busy), 32'(0));
      @(negedge clk);
      pv[p] = 1'b0;
      apply();
      #1;
      chk("exec_ready", 32'(req_ready), 32'(0));
      chk("exec_busy", 32'(busy), 32'(1));
      chk("exec_rsp_valid", 32'(rsp_valid), 32'(0));
      @(negedge clk);
      for (int i = 0; i < hold; i++) begin
         rsp_ready = 2'($urandom_range(0, 1)) << (1 - p);
         #1;
         chk("hold_rsp_valid", 32'(rsp_valid), 32'(onehot));
         chk("hold_rsp_y", rsp_y, ey);
         chk("hold_rsp_zero", 32'(rsp_zero), 32'(ez));
         chk("hold_ready", 32'(req_ready), 32'(0));
         chk("hold_busy", 32'(busy), 32'(1));
         @(negedge clk);
      end
      rsp_ready = onehot;
      #1;
      chk("rsp_valid", 32'(rsp_valid), 32'(onehot));
      chk("rsp_y", rsp_y, ey);
      chk("rsp_zero", 32'(rsp_zero), 32'(ez));
      @(negedge clk);
      rsp_ready = 2'b00;
      cnt = cnt + 1'b1;
      lg  = onehot[1];
      chk("ops_done", 32'(ops_done), 32'(cnt));
      chk("idle_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pv = 2'b00;
      apply();
      rsp_ready = 2'b00;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      lg  = 1'b1;
      cnt = '0;
      #1;
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("reset_rsp_y", rsp_y, 32'(0));
      chk("reset_rsp_zero", 32'(rsp_zero), 32'(0));
      chk("reset_ops_done", 32'(ops_done), 32'(0));
      chk("reset_ready", 32'(req_ready), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [15];
      logic [W-1:0] ey;
      int w;

      vecs[0]  = '{32'hF0F0_0000, 32'h0FF0_0001, 3'd0, 32'h00F0_0000, 1'b0};
      vecs[1]  = '{32'hF0F0_0000, 32'h0FF0_0001, 3'd1, 32'hFFF0_0001, 1'b0};
      vecs[2]  = '{32'hF0F0_0000, 32'h0FF0_0001, 3'd2, 32'h00E0_0001, 1'b0};
      vecs[3]  = '{32'hF0F0_0000, 32'h0FF0_0001, 3'd3, 32'h0000_0000, 1'b1};
      vecs[4]  = '{32'hF0F0_0000, 32'h0FF0_0001, 3'd4, 32'hF000_0000, 1'b0};
      vecs[5]  = '{32'hF0F0_0000, 32'h0FF0_0001, 3'd5, 32'hF0FF_FFFE, 1'b0};
      vecs[6]  = '{32'hF0F0_0000, 32'h0FF0_0001, 3'd6, 32'hE0FF_FFFF, 1'b0};
      vecs[7]  = '{32'hF0F0_0000, 32'h0FF0_0001, 3'd7, 32'h0000_0001, 1'b0};
      vecs[8]  = '{32'd5,         32'd7,         3'd2, 32'd12,        1'b0};
      vecs[9]  = '{32'd10,        32'd10,        3'd6, 32'd0,         1'b1};
      vecs[10] = '{32'hFFFF_FFFF, 32'd1,         3'd7, 32'd1,         1'b0};
      vecs[11] = '{32'd1,         32'hFFFF_FFFF, 3'd7, 32'd0,         1'b1};
      vecs[12] = '{32'h7FFF_FFFF, 32'd1,         3'd2, 32'h8000_0000, 1'b0};
      vecs[13] = '{32'd0,         32'd1,         3'd6, 32'hFFFF_FFFF, 1'b0};
      vecs[14] = '{32'hFFFF_FFFF, 32'd1,         3'd2, 32'd0,         1'b1};

      for (int p = 0; p < 2; p++) begin
         pa[p] = '0; pb[p] = '0; pf[p] = '0;
      end
      do_reset();

      // Reset while the accepted op is in EXEC: op is lost, nothing counted.
      pv = 2'b01; pa[0] = 32'd3; pb[0] = 32'd4; pf[0] = 3'd2;
      apply();
      #1 chk("rx_accept_ready", 32'(req_ready), 32'(1));
      @(negedge clk);
      reset = 1'b1;
      pv = 2'b00;
      apply();
      @(negedge clk);
      reset = 1'b0;
      lg = 1'b1;
      #1;
      chk("rx_busy", 32'(busy), 32'(0));
      chk("rx_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rx_ops_done", 32'(ops_done), 32'(0));
      @(negedge clk);
      chk("rx_still_idle", 32'(rsp_valid), 32'(0));

      // Single op on port 0.
      pv = 2'b01; pa[0] = 32'd5; pb[0] = 32'd7; pf[0] = 3'd2;
      apply();
      serve(0, 32'd12, 1'b0, 0);
      chk("single_ops_done", 32'(ops_done), 32'(1));

      // Tie with both ports continuously valid: 0, 1, 0.
      do_reset();
      pa[0] = 32'd10; pb[0] = 32'd10; pf[0] = 3'd6;
      pa[1] = 32'hFFFF_FFFF; pb[1] = 32'd1; pf[1] = 3'd7;
      for (int k = 0; k < 3; k++) begin
         pv = 2'b11;
         apply();
         if (k == 1) serve(1, 32'd1, 1'b0, 1);
         else        serve(0, 32'd0, 1'b1, 1);
      end

      // Response backpressure on port 1 while port 0 waits.
      pv = 2'b10; pa[1] = 32'd100; pb[1] = 32'd23; pf[1] = 3'd6;
      apply();
      #1 chk("bp_accept_ready", 32'(req_ready), 32'(2));
      @(negedge clk);
      pv = 2'b11; pa[0] = 32'hAAAA_5555; pb[0] = 32'h0F0F_0F0F; pf[0] = 3'd1;
      apply();
      #1 chk("bp_exec_ready", 32'(req_ready), 32'(0));
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         rsp_ready = 2'b01;
         #1;
         chk("bp_rsp_valid", 32'(rsp_valid), 32'(2));
         chk("bp_rsp_y", rsp_y, 32'd77);
         chk("bp_rsp_zero", 32'(rsp_zero), 32'(0));
         chk("bp_ready", 32'(req_ready), 32'(0));
         chk("bp_busy", 32'(busy), 32'(1));
         @(negedge clk);
      end
      rsp_ready = 2'b10;
      @(negedge clk);
      rsp_ready = 2'b00;
      cnt = cnt + 1'b1;
      lg = 1'b1;
      pv[1] = 1'b0;
      apply();
      chk("bp_ops_done", 32'(ops_done), 32'(cnt));
      serve(0, 32'hAFAF_5F5F, 1'b0, 0);

      // Directed table, alternating ports.
      for (int i = 0; i < 15; i++) begin
         w = i % 2;
         pv = (w == 1) ? 2'b10 : 2'b01;
         pa[w] = vecs[i].a; pb[w] = vecs[i].b; pf[w] = vecs[i].f;
         apply();
         serve(w, vecs[i].y, vecs[i].z, i % 3);
      end

      // Counter wraps to zero after the 16th completion.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         pv = 2'b01; pa[0] = $urandom; pb[0] = $urandom; pf[0] = 3'd2;
         apply();
         serve(0, pa[0] + pb[0], (pa[0] + pb[0]) == '0, 0);
         if (i == 14) chk("wrap_max", 32'(ops_done), 32'(15));
      end
      chk("wrap_zero", 32'(ops_done), 32'(0));

      // Random traffic against the transaction-level model.
      for (int it = 0; it < 300; it++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pv[p] && $urandom_range(0, 2) != 0) begin
               pv[p] = 1'b1;
               pa[p] = $urandom;
               pb[p] = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom;
               pf[p] = 3'($urandom_range(0, 7));
            end
         end
         apply();
         if (pv == 2'b00) begin
            #1 chk("rand_idle_ready", 32'(req_ready), 32'(0));
            @(negedge clk);
         end else begin
            if (pv == 2'b11) w = lg ? 0 : 1;
            else             w = pv[1] ? 1 : 0;
            ey = alu_ref(pa[w], pb[w], pf[w]);
            serve(w, ey, ey == '0, $urandom_range(0, 3));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
